pu_riscv_dmem_responder: RTL and testbench
==========================================

# pu_riscv_dmem_responder

Responder end of the core data-memory port driven by `pu_riscv_lsu`. It accepts one request at a time, checks alignment and address range, then performs a byte-lane read or write on an internal word-organised RAM after a programmable latency. Completion is signalled with `dmem_ack`, `dmem_misaligned` or `dmem_page_fault`. It serves as the reference data memory in core-level simulation and as a simple tightly-coupled data RAM.

## Interface

**Parameters**
- `XLEN`, 64: data width; 32 or 64.
- `DEPTH`, 1024: RAM depth in XLEN-wide words; power of two.
- `LATENCY`, 2: cycles from request capture to completion; 1..15.

**Ports**
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dmem_req` in 1: request valid; level, held by the LSU until completion.
- `dmem_adr` in XLEN: byte address.
- `dmem_we` in 1: 1 = store, 0 = load.
- `dmem_size` in 3: 0 = byte, 1 = half, 2 = word, 3 = dword. Code 3 is legal only when XLEN = 64; codes 4–7 are illegal.
- `dmem_d` in XLEN: store data, right-aligned (LSBs).
- `dmem_q` out XLEN: full aligned word at `dmem_adr`; valid only in the `dmem_ack` cycle.
- `dmem_ack` out 1: one-cycle completion pulse.
- `dmem_misaligned` out 1: one-cycle pulse for a misaligned or illegal-size request.
- `dmem_page_fault` out 1: one-cycle pulse for an out-of-range address.

## Operation

**States**
- IDLE: `dmem_req` = 1 captures `adr`, `we`, `size` and `d` into registers, loads the counter with LATENCY−1, and moves to CHECK.
- CHECK (one cycle): evaluate the captured request in this priority order:
  - Illegal size, or `adr` not a multiple of 2^size: go to RESP_MIS.
  - Word index `adr >> log2(XLEN/8)` ≥ DEPTH: go to RESP_PF.
  - Otherwise go to WAIT.
- WAIT: count down to 0; on 0 go to RESP_ACK.
  - With LATENCY = 1, CHECK goes directly to RESP_ACK.
- RESP_ACK: pulse `dmem_ack`; go to IDLE.
  - Store: write `d << (8*offset)` under a byte-enable mask of 2^size bytes starting at lane `offset`. Other bytes are unchanged. `dmem_q` returns the old word.
  - Load: `dmem_q` = RAM word.
- RESP_MIS / RESP_PF: pulse the corresponding flag; no RAM access; go to IDLE.

**Rules**
- Exactly one of `ack`, `misaligned` or `page_fault` pulses per captured request.
- Inputs are ignored outside IDLE.
- `dmem_req` still high in the cycle after a completion pulse (IDLE) is a new request.
- Reset in any state:
  - Return to IDLE.
  - Pending store is discarded.
  - No pulse is emitted.
  - RAM contents are not cleared.

## Timing

- All outputs are reset to 0, including `dmem_q`.
- Accepted request: completion pulse in cycle T+1+LATENCY, where T is the capture cycle.
- Faulting request: pulse in cycle T+2, independent of LATENCY.
- Maximum throughput is one request per LATENCY+2 cycles.
- `dmem_q` is registered; it holds its value outside ack cycles but is don't-care there.
- RAM write happens on the edge that ends the RESP_ACK cycle. A following load of the same word sees the new data.

## Structure

- Shared package `pu_riscv_verilog_pkg` holds:
  - Size constants `BYTE` = 0, `HWORD` = 1, `WORD` = 2, `DWORD` = 3.
  - State enum `dmem_rsp_state_t` (IDLE, CHECK, WAIT, RESP_ACK, RESP_MIS, RESP_PF).
- One sub-module, `pu_riscv_dmem_ram`:
  - Single-port, synchronous-read, byte-enable RAM of DEPTH × XLEN.
  - Read-before-write on the same port.
- Top module contains the FSM, counter, checks, lane shifting and mask generation.

## Test plan

Default parameters (XLEN = 64, DEPTH = 1024, LATENCY = 2) unless noted.

1. Store dword 0x1122334455667788 at 0x40, then load dword at 0x40.
   - Store ack in cycle T+3.
   - Load ack with `dmem_q` = 0x1122334455667788.
2. Store byte 0xAB at 0x43, then load at 0x40.
   - `dmem_q` = 0x11223344AB667788; no other lanes change.
3. Load half at 0x41, then load word at 0x44 with size 2.
   - First: `dmem_misaligned` pulses at T+2, no ack, RAM untouched.
   - Second: ack.
4. Load at 0x2000 (word index 1024).
   - `dmem_page_fault` pulses at T+2.
   - Store size 5 at 0x0: `dmem_misaligned` pulses.
5. LATENCY = 1 and LATENCY = 7, with `dmem_req` held high continuously.
   - Acks every 3 and every 9 cycles respectively.
   - Exactly one pulse per request.
6. Assert `rst` during WAIT of a store 0xFF at 0x80.
   - No ack.
   - A later load of 0x80 returns the prior contents.
   - All outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/pu_riscv_verilog_pkg.sv
// Shared definitions for the core data-memory responder: access-size codes
// and the responder state encoding.
package pu_riscv_verilog_pkg;

  localparam logic [2:0] BYTE  = 3'd0;
  localparam logic [2:0] HWORD = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] DWORD = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT,
    RESP_ACK,
    RESP_MIS,
    RESP_PF
  } dmem_rsp_state_t;

endpackage

// File: rtl/pu_riscv_dmem_ram.sv
// Single-port, synchronous-read, byte-enable RAM, DEPTH x XLEN.
// The read returns the word as it was before any write on the same edge.
module pu_riscv_dmem_ram #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int i = 0; i < XLEN/8; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/pu_riscv_dmem_responder.sv
// Responder end of the core data-memory port: one request at a time, alignment
// and range checks, then a byte-lane access to the internal RAM after LATENCY.
//
// state    | meaning
// IDLE     | waiting for dmem_req; captures the request
// CHECK    | size/alignment, then range check of the captured request
// WAIT     | latency countdown
// RESP_ACK | dmem_ack pulse; store commits at the end of this cycle
// RESP_MIS | dmem_misaligned pulse
// RESP_PF  | dmem_page_fault pulse
module pu_riscv_dmem_responder
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_size,
  input  logic [XLEN-1:0] dmem_d,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  dmem_rsp_state_t state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] adr_r;
  logic            we_r;
  logic [2:0]      size_r;
  logic [XLEN-1:0] d_r;

  logic [OFFW-1:0] off;
  logic [XLEN-1:0] adr_hi;
  logic            size_ok;
  logic            aligned;
  logic            in_range;
  logic [NB-1:0]   be_base;
  logic [IDXW-1:0] ram_addr;
  logic            ram_we;
  logic [NB-1:0]   ram_be;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_q;

  assign off      = adr_r[OFFW-1:0];
  assign adr_hi   = adr_r >> (OFFW + IDXW);
  assign in_range = (adr_hi == '0);

  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b0;
    be_base = '0;
    case (size_r)
      BYTE:  begin size_ok = 1'b1;         aligned = 1'b1;             be_base = NB'(1);   end
      HWORD: begin size_ok = 1'b1;         aligned = (adr_r[0] == 1'b0);   be_base = NB'(3);   end
      WORD:  begin size_ok = 1'b1;         aligned = (adr_r[1:0] == 2'b0); be_base = NB'(15);  end
      DWORD: begin size_ok = (XLEN == 64); aligned = (adr_r[2:0] == 3'b0); be_base = NB'(255); end
      default: begin size_ok = 1'b0; aligned = 1'b0; be_base = '0; end
    endcase
  end

  // In IDLE the RAM reads the incoming address, so the word is already
  // available in CHECK and a LATENCY of 1 can still return it.
  assign ram_addr  = (state == IDLE) ? dmem_adr[OFFW +: IDXW] : adr_r[OFFW +: IDXW];
  assign ram_we    = (state == RESP_ACK) && we_r && !rst;
  assign ram_be    = be_base << off;
  assign ram_wdata = d_r << {off, 3'b000};

  pu_riscv_dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      adr_r           <= '0;
      we_r            <= 1'b0;
      size_r          <= '0;
      d_r             <= '0;
      dmem_q          <= '0;
      dmem_ack        <= 1'b0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
    end else begin
      dmem_ack        <= 1'b0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_req) begin
            adr_r  <= dmem_adr;
            we_r   <= dmem_we;
            size_r <= dmem_size;
            d_r    <= dmem_d;
            cnt    <= 4'(LATENCY - 1);
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!size_ok || !aligned) begin
            dmem_misaligned <= 1'b1;
            state           <= RESP_MIS;
          end else if (!in_range) begin
            dmem_page_fault <= 1'b1;
            state           <= RESP_PF;
          end else if (cnt == 4'd0) begin
            dmem_ack <= 1'b1;
            dmem_q   <= ram_q;
            state    <= RESP_ACK;
          end else begin
            cnt   <= cnt - 4'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            dmem_ack <= 1'b1;
            dmem_q   <= ram_q;
            state    <= RESP_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP_ACK, RESP_MIS, RESP_PF: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_riscv_dmem_responder.sv
// Directed bench for pu_riscv_dmem_responder: one instance at LATENCY 2 for
// functional checks, two more at LATENCY 1 and 7 for back-to-back throughput.
module tb_pu_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic [63:0] adr = '0;
  logic        we = 1'b0;
  logic [2:0]  size = '0;
  logic [63:0] d = '0;

  logic [63:0] q_a, q_b, q_c;
  logic        ack_a, mis_a, pf_a;
  logic        ack_b, mis_b, pf_b;
  logic        ack_c, mis_c, pf_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .dmem_req(req_a), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .dmem_q(q_a), .dmem_ack(ack_a),
    .dmem_misaligned(mis_a), .dmem_page_fault(pf_a));

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .dmem_req(req_b), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .dmem_q(q_b), .dmem_ack(ack_b),
    .dmem_misaligned(mis_b), .dmem_page_fault(pf_b));

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024), .LATENCY(7)) dut_c (
    .clk(clk), .rst(rst), .dmem_req(req_c), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .dmem_q(q_c), .dmem_ack(ack_c),
    .dmem_misaligned(mis_c), .dmem_page_fault(pf_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on dut_a; flags are {ack, misaligned, page_fault}, exp_n is the
  // number of cycles from the capture cycle to the pulse cycle.
  task automatic xact(input logic w, input logic [2:0] sz, input logic [63:0] a,
                      input logic [63:0] wd, input logic [2:0] exp_flags, input int exp_n,
                      input logic chk_q, input logic [63:0] exp_q, input string tag);
    int n;
    logic [2:0] flags;
    we = w; size = sz; adr = a; d = wd; req_a = 1'b1;
    n = 0;
    flags = '0;
    while (n < 40 && flags == 3'b000) begin
      tick();
      n++;
      flags = {ack_a, mis_a, pf_a};
    end
    req_a = 1'b0;
    chk({tag, "_flags"}, 64'(flags), 64'(exp_flags));
    chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    if (chk_q) chk({tag, "_q"}, q_a, exp_q);
    tick();
    chk({tag, "_single"}, 64'({ack_a, mis_a, pf_a}), 64'd0);
  endtask

  initial begin : main
    int n_b, n_c, last_b, last_c, bad_b, bad_c, stray;

    repeat (3) tick();
    chk("rst_q", q_a, 64'd0);
    chk("rst_flags", 64'({ack_a, mis_a, pf_a}), 64'd0);
    rst = 1'b0;
    tick();

    // dword store / load round trip
    xact(1'b1, 3'd3, 64'h40, 64'h1122334455667788, 3'b100, 3, 1'b0, '0, "st_dw40");
    xact(1'b0, 3'd3, 64'h40, 64'h0, 3'b100, 3, 1'b1, 64'h1122334455667788, "ld_dw40");

    // byte store into lane 3; store returns the old word
    xact(1'b1, 3'd0, 64'h43, 64'hAB, 3'b100, 3, 1'b1, 64'h1122334455667788, "st_b43");
    xact(1'b0, 3'd3, 64'h40, 64'h0, 3'b100, 3, 1'b1, 64'h11223344AB667788, "ld_after_b");

    // misaligned and size checks
    xact(1'b0, 3'd1, 64'h41, 64'h0, 3'b010, 2, 1'b0, '0, "ld_h41_mis");
    xact(1'b0, 3'd2, 64'h44, 64'h0, 3'b100, 3, 1'b1, 64'h11223344AB667788, "ld_w44");
    xact(1'b0, 3'd3, 64'h44, 64'h0, 3'b010, 2, 1'b0, '0, "ld_dw44_mis");

    // out-of-range and illegal size; misaligned outranks page fault
    xact(1'b0, 3'd3, 64'h2000, 64'h0, 3'b001, 2, 1'b0, '0, "ld_2000_pf");
    xact(1'b1, 3'd5, 64'h0, 64'h0, 3'b010, 2, 1'b0, '0, "st_sz5_mis");
    xact(1'b0, 3'd1, 64'h2001, 64'h0, 3'b010, 2, 1'b0, '0, "ld_2001_mis");

    // last word in range
    xact(1'b1, 3'd3, 64'h1FF8, 64'hCAFEF00D12345678, 3'b100, 3, 1'b0, '0, "st_last");
    xact(1'b0, 3'd3, 64'h1FF8, 64'h0, 3'b100, 3, 1'b1, 64'hCAFEF00D12345678, "ld_last");

    // narrow stores with junk in the upper data bits must only touch their lanes
    xact(1'b1, 3'd1, 64'h46, 64'hFFFFFFFFFFFFBEEF, 3'b100, 3, 1'b1, 64'h11223344AB667788, "st_h46");
    xact(1'b1, 3'd0, 64'h41, 64'hFFFFFFFFFFFFFF5A, 3'b100, 3, 1'b0, '0, "st_b41");
    xact(1'b0, 3'd3, 64'h40, 64'h0, 3'b100, 3, 1'b1, 64'hBEEF3344AB665A88, "ld_merge");

    // reset during WAIT of a store discards it
    xact(1'b1, 3'd3, 64'h80, 64'h0, 3'b100, 3, 1'b0, '0, "st_dw80");
    xact(1'b0, 3'd3, 64'h40, 64'h0, 3'b100, 3, 1'b1, 64'hBEEF3344AB665A88, "ld_pre_rst");
    we = 1'b1; size = 3'd0; adr = 64'h80; d = 64'hFF; req_a = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    req_a = 1'b0;
    tick();
    chk("rst_mid_q", q_a, 64'd0);
    chk("rst_mid_flags", 64'({ack_a, mis_a, pf_a}), 64'd0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_a || mis_a || pf_a) stray++;
    end
    chk("rst_no_pulse", 64'(stray), 64'd0);
    xact(1'b0, 3'd3, 64'h80, 64'h0, 3'b100, 3, 1'b1, 64'h0, "ld_80_after_rst");

    // back-to-back requests held high at LATENCY 1 and 7
    we = 1'b0; size = 3'd3; adr = 64'h0; d = '0;
    req_b = 1'b1; req_c = 1'b1;
    n_b = 0; n_c = 0; last_b = 0; last_c = 0; bad_b = 0; bad_c = 0;
    for (int n = 1; n <= 90; n++) begin
      tick();
      if (mis_b || pf_b) bad_b++;
      if (mis_c || pf_c) bad_c++;
      if (ack_b) begin
        if (last_b == 0) chk("l1_first", 64'(n), 64'd2);
        else chk("l1_period", 64'(n - last_b), 64'd3);
        last_b = n;
        n_b++;
      end
      if (ack_c) begin
        if (last_c == 0) chk("l7_first", 64'(n), 64'd8);
        else chk("l7_period", 64'(n - last_c), 64'd9);
        last_c = n;
        n_c++;
      end
    end
    req_b = 1'b0; req_c = 1'b0;
    chk("l1_count", 64'(n_b), 64'd30);
    chk("l7_count", 64'(n_c), 64'd10);
    chk("l1_faults", 64'(bad_b), 64'd0);
    chk("l7_faults", 64'(bad_c), 64'd0);
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
